// File: rtl/sopc_mmio_responder_pkg.sv
// Shared constants for the SOPC MMIO responder: decode defaults, register
// word offsets, CTRL/STATUS bit positions and a byte-lane mask helper.
package sopc_mmio_responder_pkg;

  localparam logic [31:0] BASE_ADDR_DEF = 32'h1000_0000;
  localparam logic [31:0] BASE_MASK_DEF = 32'hFFFF_FFE0;

  localparam logic [2:0] REG_COUNT    = 3'd0;
  localparam logic [2:0] REG_COMPARE  = 3'd1;
  localparam logic [2:0] REG_CTRL     = 3'd2;
  localparam logic [2:0] REG_STATUS   = 3'd3;
  localparam logic [2:0] REG_MASK     = 3'd4;
  localparam logic [2:0] REG_GPIO_IN  = 3'd5;
  localparam logic [2:0] REG_GPIO_OUT = 3'd6;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_AR_BIT  = 1;
  localparam int CTRL_PS_LSB  = 8;
  localparam int CTRL_PS_MSB  = 15;
  localparam int STAT_TMR_BIT = 0;

  // Only enable, auto-reload and prescale exist in CTRL
  localparam logic [31:0] CTRL_IMPL_MASK = 32'h0000_FF03;

  // Expand 4 byte-lane selects into a 32-bit bit mask
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{sel[k]}};
    return m;
  endfunction

endpackage

// File: rtl/sopc_mmio_responder_gpio_edge_sync.sv
// Two-flop synchroniser for asynchronous GPIO inputs plus a rising-edge
// pulse measured against the previous synchronised sample.
module sopc_mmio_responder_gpio_edge_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] sync_o,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] meta_q, sync_q, prev_q;

  // Synchroniser chain and one-sample history for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/sopc_mmio_responder.sv
// MMIO responder on the CPU data bus: prescaled timer with compare,
// W1C interrupt status with mask, GPIO in/out, and the registered
// 6-bit interrupt vector fed back into the core.
module sopc_mmio_responder
  import sopc_mmio_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter logic [31:0] BASE_MASK = BASE_MASK_DEF,
  parameter int          GPIO_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [3:0]        sel_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  input  logic              timer_int_i,
  input  logic [GPIO_W-1:0] gpio_i,
  output logic [GPIO_W-1:0] gpio_o,
  output logic [5:0]        int_o
);

  // STATUS/MASK: bit 0 timer, bits GPIO_W:1 GPIO edges
  localparam int SW = GPIO_W + 1;

  logic              hit, wr_en, rd_en, tick, cnt_wr, match_set;
  logic [2:0]        word;
  logic [31:0]       lmask, rdata;
  logic [31:0]       count_q, count_d, compare_q, compare_d, ctrl_q, ctrl_d;
  logic [SW-1:0]     status_q, status_d, mask_q, mask_d, w1c;
  logic [GPIO_W-1:0] gout_q, gout_d, gpio_sync, gpio_rise;
  logic [7:0]        psc_q, psc_d;
  logic [5:0]        int_q, int_d;

  assign hit   = ce_i & ((addr_i & BASE_MASK) == BASE_ADDR);
  assign wr_en = hit & we_i;
  assign rd_en = hit & ~we_i;
  assign word  = addr_i[4:2];
  assign lmask = lane_mask(sel_i);

  sopc_mmio_responder_gpio_edge_sync #(.W(GPIO_W)) u_gpio_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (gpio_i),
    .sync_o  (gpio_sync),
    .rise_o  (gpio_rise)
  );

  // Prescaler: wraps at CTRL prescale and emits a tick; held at 0 when disabled
  always_comb begin
    tick  = 1'b0;
    psc_d = psc_q;
    if (!ctrl_q[CTRL_EN_BIT]) begin
      psc_d = '0;
    end else if (psc_q == ctrl_q[CTRL_PS_MSB:CTRL_PS_LSB]) begin
      psc_d = '0;
      tick  = 1'b1;
    end else begin
      psc_d = psc_q + 8'd1;
    end
  end

  // Register next-state: CPU writes per byte lane; a COUNT write suppresses tick/match
  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    ctrl_d    = ctrl_q;
    mask_d    = mask_q;
    gout_d    = gout_q;
    w1c       = '0;
    match_set = 1'b0;
    cnt_wr    = wr_en && (word == REG_COUNT);

    if (cnt_wr) begin
      count_d = (count_q & ~lmask) | (data_i & lmask);
    end else if (tick) begin
      if (count_q == compare_q) begin
        match_set = 1'b1;
        count_d   = ctrl_q[CTRL_AR_BIT] ? '0 : count_q + 32'd1;
      end else begin
        count_d = count_q + 32'd1;
      end
    end

    if (wr_en) begin
      case (word)
        REG_COMPARE:  compare_d = (compare_q & ~lmask) | (data_i & lmask);
        REG_CTRL:     ctrl_d    = (ctrl_q & ~lmask) | (data_i & lmask & CTRL_IMPL_MASK);
        REG_STATUS:   w1c       = data_i[SW-1:0] & lmask[SW-1:0];
        REG_MASK:     mask_d    = (mask_q & ~lmask[SW-1:0]) | (data_i[SW-1:0] & lmask[SW-1:0]);
        REG_GPIO_OUT: gout_d    = (gout_q & ~lmask[GPIO_W-1:0]) |
                                  (data_i[GPIO_W-1:0] & lmask[GPIO_W-1:0]);
        default: ;
      endcase
    end

    // Hardware set beats a simultaneous W1C of the same bit
    status_d = (status_q & ~w1c) | {gpio_rise, match_set};
  end

  // Interrupt vector computed from the current STATUS/MASK, registered next edge
  always_comb begin
    int_d    = '0;
    int_d[0] = status_q[STAT_TMR_BIT] & mask_q[STAT_TMR_BIT];
    int_d[1] = |(status_q[SW-1:1] & mask_q[SW-1:1]);
    int_d[5] = timer_int_i;
  end

  // Combinational read mux; zero whenever this is not a read hit
  always_comb begin
    rdata = '0;
    case (word)
      REG_COUNT:    rdata = count_q;
      REG_COMPARE:  rdata = compare_q;
      REG_CTRL:     rdata = ctrl_q;
      REG_STATUS:   rdata = 32'(status_q);
      REG_MASK:     rdata = 32'(mask_q);
      REG_GPIO_IN:  rdata = 32'(gpio_sync);
      REG_GPIO_OUT: rdata = 32'(gout_q);
      default:      rdata = '0;
    endcase
    data_o = rd_en ? rdata : '0;
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= '0;
      compare_q <= '1;
      ctrl_q    <= '0;
      status_q  <= '0;
      mask_q    <= '0;
      gout_q    <= '0;
      psc_q     <= '0;
      int_q     <= '0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ctrl_q    <= ctrl_d;
      status_q  <= status_d;
      mask_q    <= mask_d;
      gout_q    <= gout_d;
      psc_q     <= psc_d;
      int_q     <= int_d;
    end
  end

  assign gpio_o = gout_q;
  assign int_o  = int_q;

endmodule

// File: tb/tb_sopc_mmio_responder.sv
// Bench for sopc_mmio_responder: directed scenarios with literal expectations
// plus randomized bus/GPIO traffic checked every cycle against a reference model.
module tb_sopc_mmio_responder;

  localparam int          GW   = 4;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] BMSK = 32'hFFFF_FFE0;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce_i, we_i, timer_int_i;
  logic [31:0]   addr_i, data_i, data_o;
  logic [3:0]    sel_i;
  logic [GW-1:0] gpio_i, gpio_o;
  logic [5:0]    int_o;

  int checks = 0;
  int failures = 0;

  logic [31:0] last_rd;
  logic [5:0]  last_int;

  // reference model state
  logic [31:0] m_cnt, m_cmp, m_ctrl;
  logic [GW:0] m_stat, m_msk;
  logic [GW-1:0] m_gout;
  int          m_since;      // cycles since last tick while enabled
  logic [5:0]  m_int;
  logic [GW-1:0] m_hist [3]; // gpio_i as sampled 1, 2 and 3 edges ago

  sopc_mmio_responder #(.BASE_ADDR(BASE), .BASE_MASK(BMSK), .GPIO_W(GW)) dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i), .sel_i(sel_i),
    .data_i(data_i), .data_o(data_o), .timer_int_i(timer_int_i), .gpio_i(gpio_i),
    .gpio_o(gpio_o), .int_o(int_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] bytes_of(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_cmp = 32'hFFFF_FFFF; m_ctrl = 0; m_stat = 0; m_msk = 0;
    m_gout = 0; m_since = 0; m_int = 0;
    for (int i = 0; i < 3; i++) m_hist[i] = '0;
  endtask

  function automatic logic [31:0] model_read();
    if (!(ce_i && !we_i && ((addr_i & BMSK) == BASE))) return 32'h0;
    case (addr_i[4:2])
      3'd0: return m_cnt;
      3'd1: return m_cmp;
      3'd2: return m_ctrl;
      3'd3: return 32'(m_stat);
      3'd4: return 32'(m_msk);
      3'd5: return 32'(m_hist[1]);
      3'd6: return 32'(m_gout);
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model by one clock edge using the current bus inputs
  task automatic model_step();
    logic wr, tick, cw, match;
    logic [2:0] w;
    logic [31:0] lm, ps;
    logic [GW:0] clr, setb;
    wr  = ce_i && we_i && ((addr_i & BMSK) == BASE);
    w   = addr_i[4:2];
    lm  = bytes_of(sel_i);
    ps  = {24'd0, m_ctrl[15:8]};
    tick = m_ctrl[0] && (m_since == int'(ps));
    cw  = wr && (w == 3'd0);
    match = tick && !cw && (m_cnt == m_cmp);
    // interrupts see STATUS/MASK before this edge's update
    m_int = {timer_int_i, 3'b000, |(m_stat[GW:1] & m_msk[GW:1]), m_stat[0] & m_msk[0]};
    setb = {m_hist[1] & ~m_hist[2], match};
    clr  = (wr && w == 3'd3) ? (data_i[GW:0] & lm[GW:0]) : '0;
    m_stat = (m_stat & ~clr) | setb;
    if (cw) m_cnt = (m_cnt & ~lm) | (data_i & lm);
    else if (tick) m_cnt = (match && m_ctrl[1]) ? 32'h0 : m_cnt + 1;
    m_since = !m_ctrl[0] ? 0 : (tick ? 0 : m_since + 1);
    if (wr && w == 3'd1) m_cmp = (m_cmp & ~lm) | (data_i & lm);
    if (wr && w == 3'd2) m_ctrl = ((m_ctrl & ~lm) | (data_i & lm)) & 32'h0000_FF03;
    if (wr && w == 3'd4) m_msk = (m_msk & ~lm[GW:0]) | (data_i[GW:0] & lm[GW:0]);
    if (wr && w == 3'd6) m_gout = (m_gout & ~lm[GW-1:0]) | (data_i[GW-1:0] & lm[GW-1:0]);
    m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = gpio_i;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance it
  task automatic cycle();
    @(negedge clk);
    last_rd  = data_o;
    last_int = int_o;
    chk("data_o", data_o, model_read());
    chk("int_o", 32'(int_o), 32'(m_int));
    chk("gpio_o", 32'(gpio_o), 32'(m_gout));
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ce_i = 0; we_i = 0; addr_i = 0; sel_i = 0; data_i = 0;
  endtask

  task automatic bus_wr(input int w, input logic [31:0] d, input logic [3:0] s);
    ce_i = 1; we_i = 1; addr_i = BASE + 32'(w * 4); sel_i = s; data_i = d;
    cycle();
    idle();
  endtask

  task automatic bus_rd(input int w);
    ce_i = 1; we_i = 0; addr_i = BASE + 32'(w * 4); sel_i = 4'hF; data_i = 0;
    cycle();
    idle();
  endtask

  logic [31:0] tmr_exp [7] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0};
  logic [31:0] psc_exp [9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'd0, 32'd0, 32'd0, 32'd0, 32'd1};
  logic [31:0] gp_exp [4]  = '{32'd0, 32'd0, 32'd0, 32'd8};

  initial begin
    idle();
    gpio_i = 0; timer_int_i = 0;
    rst = 0;
    model_reset();
    // reset state of every offset, read while reset is held
    ce_i = 1; we_i = 0; sel_i = 4'hF;
    for (int w = 0; w < 8; w++) begin
      addr_i = BASE + 32'(w * 4);
      #3;
      chk($sformatf("rst_rd%0d", w), data_o, (w == 1) ? 32'hFFFF_FFFF : 32'h0);
    end
    chk("rst_int", 32'(int_o), 32'h0);
    idle();
    @(posedge clk); #1;
    rst = 1;

    // timer with auto-reload
    bus_wr(1, 32'd5, 4'hF);
    bus_wr(4, 32'd1, 4'hF);
    bus_wr(2, 32'h0000_0003, 4'hF);
    for (int i = 0; i < 7; i++) begin
      bus_rd(0);
      chk("tmr_count", last_rd, tmr_exp[i]);
    end
    bus_rd(3);
    chk("tmr_status", last_rd, 32'h1);
    chk("tmr_int0", 32'(last_int[0]), 32'h1);
    bus_wr(2, 32'h0, 4'hF);
    bus_wr(3, 32'h1F, 4'hF);

    // collisions: COUNT write vs tick, W1C vs match
    bus_wr(1, 32'h200, 4'hF);
    bus_wr(2, 32'h1, 4'hF);
    bus_wr(0, 32'h55, 4'hF);
    bus_rd(0);
    chk("col_cntwr", last_rd, 32'h55);
    bus_wr(0, 32'h200, 4'hF);
    bus_wr(3, 32'h1, 4'hF);
    bus_rd(3);
    chk("col_w1c_set", last_rd, 32'h1);
    bus_wr(3, 32'h1, 4'hF);
    bus_rd(3);
    chk("col_w1c_clr", last_rd, 32'h0);
    bus_wr(2, 32'h0, 4'hF);

    // prescale 3 and 32-bit wrap without flag
    bus_wr(3, 32'h1F, 4'hF);
    bus_wr(1, 32'd10, 4'hF);
    bus_wr(0, 32'hFFFF_FFFF, 4'hF);
    bus_wr(2, 32'h0000_0301, 4'hF);
    for (int i = 0; i < 9; i++) begin
      bus_rd(0);
      chk("psc_count", last_rd, psc_exp[i]);
    end
    bus_rd(3);
    chk("wrap_noflag", last_rd, 32'h0);
    bus_wr(2, 32'h0, 4'hF);

    // byte lanes, ce_i=0, out-of-block, reserved, CTRL implemented bits
    bus_wr(1, 32'hFFFF_FFFF, 4'hF);
    bus_wr(1, 32'hAABB_CCDD, 4'b0010);
    bus_rd(1);
    chk("lane_cmp", last_rd, 32'hFFFF_CCFF);
    ce_i = 0; we_i = 1; addr_i = BASE + 4; sel_i = 4'hF; data_i = 0;
    cycle();
    chk("ce0_data_o", last_rd, 32'h0);
    ce_i = 1; we_i = 1; addr_i = BASE + 32'h24;
    cycle();
    we_i = 0;
    cycle();
    chk("oob_data_o", last_rd, 32'h0);
    idle();
    bus_rd(1);
    chk("nochg_cmp", last_rd, 32'hFFFF_CCFF);
    bus_wr(7, 32'hFFFF_FFFF, 4'hF);
    bus_rd(7);
    chk("rsvd", last_rd, 32'h0);
    bus_wr(2, 32'hFFFF_FFFC, 4'hF);
    bus_rd(2);
    chk("ctrl_impl", last_rd, 32'h0000_FF00);
    bus_wr(2, 32'h0, 4'hF);

    // GPIO edge, mask, W1C, passthrough timer interrupt
    bus_wr(4, 32'h8, 4'hF);
    bus_wr(6, 32'h5, 4'hF);
    chk("gpio_o", 32'(gpio_o), 32'h5);
    gpio_i = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      bus_rd(3);
      chk("gpio_stat", last_rd, gp_exp[i]);
    end
    cycle();
    chk("gpio_int1", 32'(last_int[1]), 32'h1);
    bus_rd(5);
    chk("gpio_in", last_rd, 32'h4);
    bus_wr(3, 32'h8, 4'hF);
    cycle();
    cycle();
    chk("gpio_int1_clr", 32'(last_int[1]), 32'h0);
    timer_int_i = 1;
    cycle();
    cycle();
    chk("timer_int5", 32'(last_int[5]), 32'h1);
    timer_int_i = 0;

    // asynchronous reset mid-operation
    bus_wr(1, 32'd3, 4'hF);
    bus_wr(2, 32'h1, 4'hF);
    repeat (5) cycle();
    ce_i = 1; we_i = 0; addr_i = BASE + 4; sel_i = 4'hF;
    #2 rst = 0;
    #1;
    chk("arst_cmp", data_o, 32'hFFFF_FFFF);
    chk("arst_int", 32'(int_o), 32'h0);
    chk("arst_gpio_o", 32'(gpio_o), 32'h0);
    idle();
    @(posedge clk); #1;
    rst = 1;
    model_reset();

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      ce_i = ($urandom_range(0, 9) != 0);
      we_i = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) addr_i = $urandom();
      else addr_i = BASE + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      sel_i = 4'($urandom());
      case ($urandom_range(0, 3))
        0: data_i = $urandom();
        1: data_i = {16'd0, 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))};
        default: data_i = 32'($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 3) == 0) gpio_i = GW'($urandom());
      timer_int_i = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
